// File: rtl/cosine_sequencer.sv
// cosine_sequencer: state-bus controller for the cosine/distance datapath.
// Debounces detect, runs StartCalculation, NUM_TERMS AccumulateTerms cycles
// and CalculateDistance, then holds Report until the consumer takes the result.
// Optional build macro: COSINE_SEQ_TIMEOUT_EN adds a CalculateDistance timeout
// with a sticky error flag; without it, error is tied low and no counter exists.
module cosine_sequencer #(
  parameter int unsigned NUM_TERMS      = 6,
  parameter int unsigned ALERT_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       detect,
  input  logic       abort,
  input  logic       dp_done,
  input  logic       result_ready,
  output logic [2:0] state,
  output logic [3:0] term_idx,
  output logic       busy,
  output logic       result_valid,
  output logic       error
);

  typedef enum logic [2:0] {
    ST_STANDBY = 3'd0,
    ST_ALERT   = 3'd1,
    ST_START   = 3'd2,
    ST_ACCUM   = 3'd3,
    ST_CALC    = 3'd4,
    ST_REPORT  = 3'd5
  } state_e;

  localparam logic [3:0] LAST_TERM  = 4'(NUM_TERMS);
  localparam logic [7:0] ALERT_LAST = 8'(ALERT_CYCLES - 1);

  // Reject illegal configurations at elaboration time.
  if (NUM_TERMS < 1 || NUM_TERMS > 15) begin : g_bad_terms
    $error("cosine_sequencer: NUM_TERMS out of range 1..15");
  end
  if (ALERT_CYCLES < 1 || ALERT_CYCLES > 255) begin : g_bad_alert
    $error("cosine_sequencer: ALERT_CYCLES out of range 1..255");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("cosine_sequencer: TIMEOUT_CYCLES out of range 2..65535");
  end

  state_e     state_q, state_d;
  logic [3:0] term_q, term_d;
  logic [7:0] alert_q, alert_d;
  // Low during the first CalculateDistance cycle so a stale dp_done is ignored.
  logic       armed_q, armed_d;
  logic       busy_q, valid_q;

`ifdef COSINE_SEQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_q, to_d;
  logic        err_q, err_d;
`endif

  // Next-state, term index, debounce counter and (optional) timeout logic.
  always_comb begin
    state_d = state_q;
    term_d  = term_q;
    alert_d = alert_q;
    armed_d = 1'b0;
`ifdef COSINE_SEQ_TIMEOUT_EN
    to_d    = 16'd0;
    err_d   = err_q;
`endif
    case (state_q)
      ST_STANDBY: begin
        term_d  = 4'd0;
        alert_d = 8'd0;
        if (detect) begin
          state_d = ST_ALERT;
        end else begin
          state_d = ST_STANDBY;
        end
      end
      ST_ALERT: begin
        if (abort || !detect) begin
          state_d = ST_STANDBY;
          alert_d = 8'd0;
        end else if (alert_q == ALERT_LAST) begin
          state_d = ST_START;
          alert_d = 8'd0;
`ifdef COSINE_SEQ_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end else begin
          alert_d = alert_q + 8'd1;
        end
      end
      ST_START: begin
        if (abort) begin
          state_d = ST_STANDBY;
          term_d  = 4'd0;
        end else begin
          state_d = ST_ACCUM;
          term_d  = 4'd1;
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          state_d = ST_STANDBY;
          term_d  = 4'd0;
        end else if (term_q == LAST_TERM) begin
          state_d = ST_CALC;
          term_d  = 4'd0;
        end else begin
          term_d  = term_q + 4'd1;
        end
      end
      ST_CALC: begin
        armed_d = 1'b1;
        if (abort) begin
          state_d = ST_STANDBY;
          armed_d = 1'b0;
        end else if (armed_q && dp_done) begin
          state_d = ST_REPORT;
          armed_d = 1'b0;
        end else begin
`ifdef COSINE_SEQ_TIMEOUT_EN
          if (to_q == TIMEOUT_LAST) begin
            state_d = ST_STANDBY;
            armed_d = 1'b0;
            err_d   = 1'b1;
          end else begin
            to_d    = to_q + 16'd1;
          end
`else
          state_d = ST_CALC;
`endif
        end
      end
      ST_REPORT: begin
        if (result_ready) begin
          state_d = ST_STANDBY;
        end else begin
          state_d = ST_REPORT;
        end
      end
      default: begin
        state_d = ST_STANDBY;
        term_d  = 4'd0;
        alert_d = 8'd0;
      end
    endcase
  end

  // State registers and registered status outputs; clear_n wins over everything.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q <= ST_STANDBY;
      term_q  <= 4'd0;
      alert_q <= 8'd0;
      armed_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef COSINE_SEQ_TIMEOUT_EN
      to_q    <= 16'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      alert_q <= alert_d;
      armed_q <= armed_d;
      busy_q  <= (state_d == ST_START) || (state_d == ST_ACCUM) || (state_d == ST_CALC);
      valid_q <= (state_d == ST_REPORT);
`ifdef COSINE_SEQ_TIMEOUT_EN
      to_q    <= to_d;
      err_q   <= err_d;
`endif
    end
  end

  assign state        = state_q;
  assign term_idx     = term_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
`ifdef COSINE_SEQ_TIMEOUT_EN
  assign error        = err_q;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_cosine_sequencer.sv
// Directed bench for cosine_sequencer (NUM_TERMS=6, ALERT_CYCLES=4).
// Each table row gives the inputs driven during a cycle and the state/term
// expected to be visible in that same cycle.
module tb_cosine_sequencer;

  logic       clk = 1'b0;
  logic       clear_n, detect, abort, dp_done, result_ready;
  logic [2:0] state;
  logic [3:0] term_idx;
  logic       busy, result_valid, error;

  int checks = 0;
  int errors = 0;

  cosine_sequencer #(
    .NUM_TERMS(6), .ALERT_CYCLES(4), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .clear_n(clear_n), .detect(detect), .abort(abort),
    .dp_done(dp_done), .result_ready(result_ready), .state(state),
    .term_idx(term_idx), .busy(busy), .result_valid(result_valid),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cn, det, ab, dd, rr;
    logic [2:0] st;
    logic [3:0] ti;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic cn, input logic det, input logic ab,
                     input logic dd, input logic rr,
                     input logic [2:0] st, input logic [3:0] ti);
    vec_t v;
    v.cn = cn; v.det = det; v.ab = ab; v.dd = dd; v.rr = rr;
    v.st = st; v.ti = ti;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run through StartCalculation and AccumulateTerms, then finish per mode:
  // 0 nominal, 1 dp_done stale on CD entry + abort in Report,
  // 2 abort with dp_done, 3 clear in CD, 4 clear in Report.
  task automatic add_run(input int mode);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0);
    for (int i = 1; i <= 6; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 4'(i));
    case (mode)
      0: begin
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 4'd0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 4'd0);
        for (int i = 0; i < 3; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 4'd0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 4'd0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      end
      1: begin
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 4'd0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 4'd0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5, 4'd0);
        add(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 4'd0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      end
      2: begin
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 4'd0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 4'd0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      end
      3: begin
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 4'd0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      end
      default: begin
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 4'd0);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 4'd0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 4'd0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      end
    endcase
  endtask

  initial begin
    int n;
    int bad;
    clear_n = 1'b0; detect = 1'b0; abort = 1'b0; dp_done = 1'b0; result_ready = 1'b0;

    // Nominal run
    add_run(0);
    // Detect glitch (abort in StandBy ignored on the first cycle)
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    // Abort in AccumulateTerms at term 3
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'd0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 4'd1);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 4'd2);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'd3);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
    add_run(0);
    add_run(1);
    add_run(2);
    add_run(3);
    add_run(4);
    add_run(0);

    // Reset
    step();
    step();
    clear_n = 1'b1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_term", 32'(term_idx), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(result_valid), 32'd0);
    check("reset_error", 32'(error), 32'd0);

    foreach (vecs[i]) begin
      clear_n = vecs[i].cn; detect = vecs[i].det; abort = vecs[i].ab;
      dp_done = vecs[i].dd; result_ready = vecs[i].rr;
      check($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("v%0d_term", i), 32'(term_idx), 32'(vecs[i].ti));
      check($sformatf("v%0d_busy", i), 32'(busy),
            32'((vecs[i].st >= 3'd2) && (vecs[i].st <= 3'd4)));
      check($sformatf("v%0d_valid", i), 32'(result_valid), 32'(vecs[i].st == 3'd5));
      check($sformatf("v%0d_error", i), 32'(error), 32'd0);
      step();
    end
    clear_n = 1'b1; detect = 1'b0; abort = 1'b0; dp_done = 1'b0; result_ready = 1'b0;

`ifdef COSINE_SEQ_TIMEOUT_EN
    // Timeout: 64 cycles in CalculateDistance without dp_done
    detect = 1'b1;
    n = 0;
    while (state !== 3'd4 && n < 40) begin step(); n++; end
    check("to_reach_calc", 32'(state), 32'd4);
    detect = 1'b0;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (state !== 3'd4) bad++;
      step();
    end
    check("to_calc_cycles", 32'(bad), 32'd0);
    check("to_state", 32'(state), 32'd0);
    check("to_error", 32'(error), 32'd1);
    step();
    check("to_error_standby", 32'(error), 32'd1);
    detect = 1'b1;
    step();
    check("to_alert_state", 32'(state), 32'd1);
    check("to_error_alert", 32'(error), 32'd1);
    n = 0;
    while (state !== 3'd2 && n < 20) begin step(); n++; end
    check("to_start_state", 32'(state), 32'd2);
    check("to_error_cleared", 32'(error), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0; detect = 1'b0;
    check("to_abort_state", 32'(state), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cosine_sequencer.md
Name: cosine_sequencer

Overview:
- FSM controller that drives the 3-bit `state` bus of the cosine/distance datapath.
- Debounces an object-detect input, then sequences StartCalculation, a configurable number of AccumulateTerms iterations and CalculateDistance.
- Presents the finished distance through a valid/ready handshake.
- Provides the per-iteration term index the datapath uses to select series coefficients.

Parameters:
- NUM_TERMS, 6, number of AccumulateTerms cycles (series terms after 1.0); legal 1..15.
- ALERT_CYCLES, 4, consecutive detect-high cycles spent in Alert before a calculation starts; legal 1..255.
- TIMEOUT_CYCLES, 64, max cycles in CalculateDistance waiting for dp_done; used only with the optional feature; legal 2..65535.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- clear_n  in  1  reset, synchronous, active-low; highest priority.
- detect  in  1  object-detect level from sensor logic.
- abort  in  1  cancel an in-progress run.
- dp_done  in  1  datapath done flag (datapath Done register output).
- result_ready  in  1  consumer accepts the distance.
- state  out  3  datapath state code.
- term_idx  out  4  current series term index; 0 outside a run.
- busy  out  1  high while state is 2, 3 or 4.
- result_valid  out  1  distance on the datapath output is valid.
- error  out  1  sticky timeout flag; tied 0 without the optional feature.

Behaviour:
- State codes: StandBy=0, Alert=1, StartCalculation=2, AccumulateTerms=3, CalculateDistance=4, Report=5. The datapath treats 5 as idle. Codes 6 and 7 are unreachable; if entered they return to StandBy on the next edge.
- Reset (clear_n=0 at a clock edge):
  - state=0, term_idx=0, alert counter=0, timeout counter=0.
  - busy=0, result_valid=0, error=0.
  - Reset applies from any state, including mid-run.
- Outputs: all are registered, or decoded only from registered state. No combinational path from inputs to outputs.
- StandBy: detect=1 -> Alert with alert counter=0; otherwise stay.
- Alert:
  - detect=0 -> StandBy.
  - Else, if counter==ALERT_CYCLES-1 -> StartCalculation.
  - Else counter+1.
  - Result: with detect held, Alert lasts exactly ALERT_CYCLES cycles.
- StartCalculation: exactly 1 cycle; term_idx<=1; -> AccumulateTerms.
- AccumulateTerms:
  - Lasts exactly NUM_TERMS cycles; term_idx shows 1..NUM_TERMS, one value per cycle.
  - In the cycle with term_idx==NUM_TERMS -> CalculateDistance; term_idx<=0.
- CalculateDistance:
  - dp_done is ignored in the first cycle (stale-flag guard).
  - From the second cycle on, dp_done=1 -> Report.
  - Otherwise stay.
- Report:
  - result_valid=1 throughout.
  - result_ready=1 -> StandBy next edge; result_valid drops with the state change.
  - detect is ignored in Report.
- Abort:
  - abort=1 in state 1, 2, 3 or 4 -> StandBy next edge; term_idx=0; counters cleared.
  - abort in StandBy or Report is ignored.
  - clear_n=0 outranks abort.
- Simultaneous events:
  - abort and dp_done in the same cycle of CalculateDistance: abort wins.
  - result_ready with abort in Report: handshake completes normally.
- Latency, detect rising in StandBy cycle 0, detect held:
  - Alert: cycles 1..A.
  - StartCalculation: cycle A+1.
  - AccumulateTerms: cycles A+2..A+1+N.
  - CalculateDistance: from cycle A+2+N.
  - Earliest Report: cycle A+4+N, with dp_done high at cycle A+3+N.

Optional Feature:
- Macro: COSINE_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs while in CalculateDistance.
  - If TIMEOUT_CYCLES cycles elapse without an accepted dp_done -> StandBy and error<=1.
  - error is sticky; it clears on clear_n=0 or on entry to StartCalculation.
- Undefined:
  - CalculateDistance waits indefinitely for dp_done.
  - error is constant 0 and no timeout counter is synthesised.

Test Plan:
1. Nominal run, A=4, N=6, detect held, dp_done rising at cycle 13 -> state sequence 0,1,1,1,1,2,3×6,4,4,5; term_idx 1..6 in cycles 6..11; result_valid=1 at cycle 14. result_ready at cycle 17 -> state=0 and result_valid=0 at cycle 18.
2. Detect glitch: detect high cycles 0..2, low at cycle 3 -> Alert in cycles 1..3, StandBy at cycle 4; state never 2; busy stays 0.
3. Abort at AccumulateTerms with term_idx=3 -> next cycle state=0, term_idx=0, busy=0; later full run completes normally.
4. dp_done held high on entry to CalculateDistance -> remains in state 4 for the first cycle; Report on the following edge.
5. clear_n=0 for 1 cycle during CalculateDistance, and separately during Report -> state=0, term_idx=0, result_valid=0, error=0 at the next edge.
6. COSINE_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, dp_done held 0 -> state=0 and error=1 after 64 cycles in state 4; error stays 1 through StandBy/Alert and clears on entry to StartCalculation.
